// File: rtl/ahb_decoder_mux_pkg.sv
// rtl/ahb_decoder_mux_pkg.sv - shared AHB-Lite types and constants for the decoder/mux
package ahb_decoder_mux_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ERR_IDLE = 2'd0,
        ERR_ERR1 = 2'd1,
        ERR_ERR2 = 2'd2
    } ahb_err_state_t;

    // NONSEQ and SEQ are the only transfer types that need a data phase
    function automatic logic is_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/ahb_decoder_mux_if.sv
// rtl/ahb_decoder_mux_if.sv - manager and satellite bus signals of the AHB-Lite decoder/mux
interface ahb_decoder_mux_if #(
    parameter int NSLV = 4
);
    logic [31:0]        m_haddr;
    logic [1:0]         m_htrans;
    logic               m_hwrite;
    logic [2:0]         m_hsize;
    logic [31:0]        m_hwdata;
    logic [31:0]        m_hrdata;
    logic               m_hready;
    logic               m_hresp;
    logic [NSLV-1:0]    s_hsel;
    logic               s_hready;
    logic [NSLV-1:0]    s_hreadyout;
    logic [NSLV-1:0]    s_hresp;
    logic [NSLV*32-1:0] s_hrdata;

    modport slave (
        input  m_haddr, m_htrans, m_hwrite, m_hsize, m_hwdata,
        input  s_hreadyout, s_hresp, s_hrdata,
        output m_hrdata, m_hready, m_hresp, s_hsel, s_hready
    );

    modport master (
        output m_haddr, m_htrans, m_hwrite, m_hsize, m_hwdata,
        output s_hreadyout, s_hresp, s_hrdata,
        input  m_hrdata, m_hready, m_hresp, s_hsel, s_hready
    );
endinterface

// File: rtl/ahb_decoder_mux_default_subordinate.sv
// rtl/ahb_decoder_mux_default_subordinate.sv - two-cycle ERROR responder with decode-error diagnostics
module ahb_default_subordinate
    import ahb_decoder_mux_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        hready,
    input  logic        miss,
    input  logic [31:0] haddr,
    output logic        def_hready,
    output logic        def_hresp,
    output logic [7:0]  err_count,
    output logic [31:0] err_addr
);
    ahb_err_state_t state, next_state;
    logic           load;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ERR_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            ERR_IDLE: begin
                if (hready && miss) begin
                    next_state = ERR_ERR1;
                    load       = 1'b1;
                end
            end
            ERR_ERR1: next_state = ERR_ERR2;
            ERR_ERR2: begin
                if (miss) begin
                    next_state = ERR_ERR1;
                    load       = 1'b1;
                end else begin
                    next_state = ERR_IDLE;
                end
            end
            default: next_state = ERR_IDLE;
        endcase
    end

    // Outputs depend on state only, so hready never loops back through this block
    assign def_hready = (state != ERR_ERR1);
    assign def_hresp  = (state == ERR_IDLE) ? HRESP_OKAY : HRESP_ERROR;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_count <= 8'h00;
            err_addr  <= 32'h0;
        end else if (load) begin
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'h01;
            end
            err_addr <= haddr;
        end
    end
endmodule

// File: rtl/ahb_decoder_mux.sv
// rtl/ahb_decoder_mux.sv - single-manager AHB-Lite address decoder and response multiplexer
module ahb_decoder_mux
    import ahb_decoder_mux_pkg::*;
#(
    parameter int                 NSLV     = 4,
    parameter logic [NSLV*32-1:0] SLV_BASE = {32'h2003_0000, 32'h2002_0000, 32'h2001_0000, 32'h2000_0000},
    parameter logic [NSLV*32-1:0] SLV_MASK = {4{32'hFFFF_0000}}
) (
    input  logic               clk,
    input  logic               nrst,
    ahb_decoder_mux_if.slave   bus,
    output logic [7:0]         err_count,
    output logic [31:0]        err_addr
);
    logic [NSLV-1:0] hit;
    logic [NSLV-1:0] hsel;
    logic            miss;
    logic [NSLV:0]   dsel;
    logic            hready;
    logic            hresp;
    logic [31:0]     hrdata;
    logic            def_hready;
    logic            def_hresp;
    logic            unused_fanout;

    assign unused_fanout = ^{bus.m_hwrite, bus.m_hsize, bus.m_hwdata};

    always_comb begin
        hit = '0;
        for (int i = 0; i < NSLV; i++) begin
            hit[i] = (bus.m_haddr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32];
        end
    end

    // Scan downwards so the lowest-index window wins when windows overlap
    always_comb begin
        hsel = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hsel    = '0;
                hsel[i] = 1'b1;
            end
        end
    end

    assign miss = ~|hit & is_active(bus.m_htrans);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dsel <= '0;
        end else if (hready) begin
            dsel <= is_active(bus.m_htrans) ? {miss, hsel} : '0;
        end
    end

    always_comb begin
        hrdata = 32'h0;
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        if (dsel[NSLV]) begin
            hready = def_hready;
            hresp  = def_hresp;
        end else begin
            for (int i = 0; i < NSLV; i++) begin
                if (dsel[i]) begin
                    hrdata = bus.s_hrdata[32*i +: 32];
                    hready = bus.s_hreadyout[i];
                    hresp  = bus.s_hresp[i];
                end
            end
        end
    end

    assign bus.s_hsel   = hsel;
    assign bus.s_hready = hready;
    assign bus.m_hready = hready;
    assign bus.m_hresp  = hresp;
    assign bus.m_hrdata = hrdata;

    ahb_default_subordinate u_default_sub (
        .clk        (clk),
        .nrst       (nrst),
        .hready     (hready),
        .miss       (miss),
        .haddr      (bus.m_haddr),
        .def_hready (def_hready),
        .def_hresp  (def_hresp),
        .err_count  (err_count),
        .err_addr   (err_addr)
    );
endmodule
